// File: rtl/impulse_pkg.sv
// Shared definitions for the held-impulse synapse line (generator and receiver sides).
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package impulse_pkg;

  // Nominal impulse width driven by the upstream generator.
  localparam int DEF_HOLD_TIME = 8;
  localparam int DEF_MAX_WIDTH = 4 * DEF_HOLD_TIME;
  localparam int DEF_WW        = $clog2(DEF_MAX_WIDTH + 1);

  // Pulse-width measurement FSM.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } imp_state_t;

  // Event record for the default line configuration, as seen by the membrane integrator.
  typedef struct packed {
    logic [DEF_WW-1:0] width;
    logic              burst;
  } imp_event_t;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/impulse_event_fifo.sv
// Two-entry FIFO holding measured impulse events, head presented as registered data.
// Latency: a push is visible at the head the cycle after it is written into an empty queue.
// Backpressure: pop on pop_rdy with a non-empty queue; a push into a full queue without a pop is discarded.
module impulse_event_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_rdy,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic          pop, push;

  // Pop shifts slot1 into the head; push then lands in the first free slot.
  always_comb begin
    pop     = (cnt_q != 2'd0) && pop_rdy;
    push    = push_vld && ((cnt_q != 2'd2) || pop);
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) slot0_d = push_dat;
      else               slot1_d = push_dat;
      cnt_d = cnt_d + 2'd1;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign head_dat = slot0_q;
  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);

endmodule

// File: rtl/impulse_receiver.sv
// Measures high pulses on synin, rejects glitches, queues accepted impulses as events.
// Latency: event visible the cycle after the falling edge of synin is sampled.
// Backpressure: 2-entry queue; an event arriving with the queue full and no pop is dropped and flagged.
module impulse_receiver
  import impulse_pkg::*;
#(
  parameter int  HOLD_TIME = DEF_HOLD_TIME,
  parameter int  MIN_WIDTH = HOLD_TIME,
  parameter int  MAX_WIDTH = 4 * HOLD_TIME,
  localparam int WW        = $clog2(MAX_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          synin,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [WW-1:0] ev_width,
  output logic          ev_burst,
  output logic          stuck,
  output logic          overflow,
  output logic [7:0]    glitch_cnt
);

  localparam logic [WW-1:0] MIN_W  = WW'(MIN_WIDTH);
  localparam logic [WW-1:0] MAX_W  = WW'(MAX_WIDTH);
  localparam logic [WW-1:0] HOLD_W = WW'(HOLD_TIME);
  localparam logic [WW-1:0] ONE_W  = WW'(1);

  typedef struct packed {
    logic [WW-1:0] width;
    logic          burst;
  } ev_t;

  imp_state_t    state_q, state_d;
  logic [WW-1:0] width_q, width_d;
  logic          stuck_q, stuck_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    glitch_q, glitch_d;

  logic fall_vld, accept_vld, reject_vld, drop_vld;
  ev_t  push_dat, head_dat;
  logic fifo_full, fifo_empty;

  // Classify a pulse at the cycle its falling edge is sampled.
  always_comb begin
    fall_vld       = (state_q == COUNT) && !synin;
    accept_vld     = fall_vld && (width_q >= MIN_W);
    reject_vld     = fall_vld && (width_q < MIN_W);
    push_dat.width = width_q;
    push_dat.burst = (width_q > HOLD_W);
    // Same-cycle pop frees the slot, so a full queue only drops without ev_ready.
    drop_vld       = accept_vld && fifo_full && !ev_ready;
  end

  // Next-state for the width FSM, saturating width counter and status flags.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    glitch_d   = glitch_q;
    overflow_d = overflow_q | drop_vld;
    if (reject_vld) glitch_d = sat_inc8(glitch_q);
    case (state_q)
      IDLE: begin
        if (synin) begin
          state_d = COUNT;
          width_d = ONE_W;
        end
      end
      COUNT: begin
        if (synin) begin
          if (width_q != MAX_W) width_d = width_q + ONE_W;
        end else begin
          state_d = IDLE;
          width_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        width_d = '0;
      end
    endcase
    // Registered so stuck rises with the saturating sample and falls with the release.
    stuck_d = (state_d == COUNT) && (width_d == MAX_W);
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      width_q    <= '0;
      stuck_q    <= 1'b0;
      overflow_q <= 1'b0;
      glitch_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      stuck_q    <= stuck_d;
      overflow_q <= overflow_d;
      glitch_q   <= glitch_d;
    end
  end

  impulse_event_fifo #(
    .DW($bits(ev_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (accept_vld),
    .push_dat (push_dat),
    .pop_rdy  (ev_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ev_valid   = !fifo_empty;
  assign ev_width   = head_dat.width;
  assign ev_burst   = head_dat.burst;
  assign stuck      = stuck_q;
  assign overflow   = overflow_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: doc/impulse_receiver.md
# impulse_receiver

Receiving end of the held-impulse synapse line. Samples one single-bit synaptic input driven by an upstream impulse generator, measures the width of each high pulse, and classifies it. Rejects short glitches. Delivers each accepted impulse as one event on a valid/ready interface, buffered in a 2-entry queue. Sits at the dendrite side of a neuron, feeding the membrane integrator.

## Interface
- HOLD_TIME, 8: nominal impulse width in clocks, matching the upstream generator.
- MIN_WIDTH, HOLD_TIME: minimum accepted pulse width; shorter pulses are glitches. Legal range 1..MAX_WIDTH.
- MAX_WIDTH, 4*HOLD_TIME: width counter saturation value.
- WW (localparam) = $clog2(MAX_WIDTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- synin  in  1  synaptic impulse line; same clock domain, registered upstream.
- ev_valid  out  1  queue head holds an event.
- ev_ready  in  1  consumer accepts head when high with ev_valid.
- ev_width  out  WW  measured width of head event.
- ev_burst  out  1  head width > HOLD_TIME (merged/retriggered impulses).
- stuck  out  1  high while the current pulse has reached MAX_WIDTH.
- overflow  out  1  sticky: an accepted event was dropped on a full queue.
- glitch_cnt  out  8  saturating count of rejected pulses.

## Operation
- Reset values: FSM IDLE, width counter 0, queue empty, ev_valid 0, ev_width 0, ev_burst 0, stuck 0, overflow 0, glitch_cnt 0.
- FSM states: IDLE, COUNT.
  - IDLE, synin=1: go to COUNT, width<=1.
  - IDLE, synin=0: stay.
  - COUNT, synin=1: width<=min(width+1, MAX_WIDTH); stay.
  - COUNT, synin=0 (falling edge): evaluate width, width<=0, go to IDLE.
- Evaluation on falling edge:
  - width < MIN_WIDTH: glitch. glitch_cnt<=glitch_cnt+1, saturating at 255. No event.
  - width >= MIN_WIDTH: push {width, width>HOLD_TIME} into the queue.
- stuck = (state==COUNT && width==MAX_WIDTH), registered. Clears the cycle after the falling edge is sampled. A saturated pulse still produces an event with ev_width=MAX_WIDTH and ev_burst=1.
- Queue: 2 entries, FIFO order. Pop when ev_valid && ev_ready. Head outputs hold stable while ev_valid=1 and ev_ready=0.
- Push onto a full queue with no pop that cycle: event dropped, overflow<=1. overflow is sticky until reset.
- Push and pop in the same cycle on a full queue: both succeed, no overflow.
- Push and pop in the same cycle on a 1-entry queue: count stays 1, new event becomes head.
- Reset mid-pulse: FSM returns to IDLE immediately. If synin is still high after reset release, a fresh partial pulse is measured from width 1.

## Timing
- Pulse high on synin during cycles a..b (width W=b-a+1): synin=0 is first sampled at cycle b+1, and the event is visible with ev_valid=1 at cycle b+2.
- Upstream generator fire at cycle t: line high t+1..t+8, event visible at t+10, width 8.
- Back-to-back pulses need at least one low cycle between them; a single low cycle is enough to separate two events.
- glitch_cnt updates the cycle after the falling edge is sampled.
- overflow updates the cycle after the falling edge is sampled.
- No combinational path from ev_ready to ev_valid or the event fields.

## Structure
- Shared package impulse_pkg: FSM state enum (IDLE, COUNT); event record type {width[WW-1:0], burst}; default HOLD_TIME constant shared with the generator.
- Sub-module impulse_event_fifo: 2-deep valid/ready FIFO, parameterised on data width, exposing full/empty. The FSM, width counter, and glitch counter stay in the top level.

## Test plan
- Single nominal pulse: synin high 8 cycles -> one event at falling-sample+1, ev_width=8, ev_burst=0, glitch_cnt=0.
- Glitch: synin high 3 cycles with MIN_WIDTH=8 -> no event; glitch_cnt 0->1. Run 260 glitches -> glitch_cnt saturates at 255.
- Retriggered burst: synin high 13 cycles -> ev_width=13, ev_burst=1. Stuck high 40 cycles with MAX_WIDTH=32 -> stuck=1 from the 32nd high cycle; on release, event with ev_width=32, ev_burst=1.
- Backpressure: ev_ready=0, three 8-cycle pulses separated by 1 low cycle -> two events queued in order, third dropped, overflow=1. Then ev_ready=1 -> two pops, overflow stays 1.
- Full queue with simultaneous push/pop: ev_ready asserted in the exact push cycle -> no overflow, FIFO order preserved.
- Reset at cycle 4 of an 8-cycle pulse, synin held high 4 more cycles -> after reset release: glitch_cnt=1, no event, all outputs at reset values meanwhile.
